// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default sizing.
package timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_PRESCALE = 1;
    localparam int unsigned DEFAULT_PS_W     = 8;

endpackage : timer_pkg

// File: rtl/dec16.sv
// Combinational decrementer, the mirror of the incrementer: o_out = i_a - 1 modulo 2^WIDTH.
module dec16
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_out
);

    // Wraps 0 -> all-ones; the timer never presents 0 here while counting.
    always_comb begin
        o_out = i_a - WIDTH'(1);
    end

endmodule : dec16

// File: rtl/countdown_timer16.sv
// Loadable down-counter timer with prescaler, one-cycle done pulse and optional auto-reload.
module countdown_timer16
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned PS_W     = DEFAULT_PS_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_reload_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_running,
    output logic             o_done,
    output logic             o_zero
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PS_W-1:0]  r_ps;
    logic             r_done;
    logic [WIDTH-1:0] w_count_dec;
    logic             w_tick;
    logic             w_count_zero;
    logic             w_count_one;

    dec16 #(
        .WIDTH (WIDTH)
    ) u_dec (
        .i_a   (r_count),
        .o_out (w_count_dec)
    );

    // Tick strobe and count decodes used by the FSM.
    always_comb begin
        w_tick       = (r_ps == PS_LAST);
        w_count_zero = (r_count == '0);
        w_count_one  = (r_count == WIDTH'(1));
    end

    // FSM, prescaler and counter; priority reset > load > stop > start > tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_ps     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                // State untouched: a load while running restarts the interval.
                r_count  <= i_load_value;
                r_reload <= i_load_value;
                r_ps     <= '0;
            end else if (i_stop) begin
                // Also masks a simultaneous start while idle.
                if (r_state == ST_RUN) begin
                    r_state <= ST_IDLE;
                    r_ps    <= '0;
                end
            end else if (i_start && (r_state == ST_IDLE)) begin
                if (w_count_zero) begin
                    r_done <= 1'b1;
                end else begin
                    r_state <= ST_RUN;
                    r_ps    <= '0;
                end
            end else if (r_state == ST_RUN) begin
                if (w_tick) begin
                    r_ps <= '0;
                    if (w_count_one) begin
                        r_done <= 1'b1;
                        if (i_reload_en && (r_reload != '0)) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_count_zero) begin
                        // Only reachable after loading 0 mid-run: park without wrapping.
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= w_count_dec;
                    end
                end else begin
                    r_ps <= r_ps + PS_W'(1);
                end
            end
        end
    end

    // Output decodes.
    always_comb begin
        o_count   = r_count;
        o_running = (r_state == ST_RUN);
        o_done    = r_done;
        o_zero    = w_count_zero;
    end

endmodule : countdown_timer16

// File: doc/countdown_timer16.md
Name: countdown_timer16

Overview:
- 16-bit loadable down-counter timer. It is the decrement-direction counterpart of the incrementer and program-counter datapath.
- Counts a loaded value down to zero at a prescaled rate. Flags expiry with a one-cycle done pulse. Optionally auto-reloads.
- Used as the interval/delay source beside the CPU and PC in the hack platform, and as a stimulus pacer in benches.

Parameters:
- WIDTH, 16: counter and load-value width.
- PRESCALE, 1: clock cycles per decrement. Legal range ≥1.
- PS_W, 8: prescaler counter width. Requires PRESCALE ≤ 2^PS_W.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load load_value into count and reload register.
- load_value  in  WIDTH  value captured on load.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting; count is held.
- reload_en  in  1  auto-reload on expiry when high.
- count  out  WIDTH  current counter value (registered).
- running  out  1  high while in the RUN state.
- done  out  1  registered one-cycle pulse on expiry.
- zero  out  1  combinational, equals (count == 0).

Behaviour:
- Reset: reset is synchronous and active-high. On the reset edge:
  - state becomes IDLE.
  - count, reload_reg, prescaler and done become 0; running becomes 0.
  - reset overrides every other input.
- States: IDLE, RUN. running = (state == RUN), registered with the state.
- Input priority per cycle: reset > load > stop > start > tick.
- load, in any state:
  - count and reload_reg take load_value; prescaler clears; done becomes 0.
  - State is unchanged: a load during RUN restarts the interval without stopping.
- stop in RUN: go to IDLE. count holds, prescaler clears. stop in IDLE has no effect.
- stop and start in the same cycle: stop wins.
- start in IDLE with count != 0: go to RUN; the prescaler starts from 0.
- start in IDLE with count == 0: done pulses on the next edge; state stays IDLE.
- start in RUN has no effect.
- Tick in RUN occurs when prescaler == PRESCALE-1. Otherwise the prescaler increments.
  - On a tick the prescaler returns to 0.
  - With PRESCALE=1, every RUN cycle is a tick.
- Tick with count > 1: count <= count - 1.
- Tick with count == 1 (expiry): done <= 1 for exactly one cycle, registered on the same edge that count updates. Then:
  - reload_en high and reload_reg != 0: count <= reload_reg; stay in RUN.
  - Otherwise: count <= 0; go to IDLE.
- No underflow: count never wraps below 0. A decrement from 0 never occurs.
- Decrement arithmetic is modulo 2^WIDTH, implemented through the decrement sub-module.
- Latency:
  - First decrement occurs PRESCALE cycles after the start edge.
  - Expiry occurs N*PRESCALE cycles after start for a loaded value N.
- load on the expiry cycle: load wins, and no done pulse is produced.
- reset mid-RUN: returns to IDLE immediately. No done pulse.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - default WIDTH and PRESCALE constants.
- One natural sub-module: dec16, a combinational out = a - 1. It is the mirror of the existing incrementer and is separately testable with the same vector-file bench style.
- The FSM, prescaler and registers live in countdown_timer16.

Test Plan:
1. reset, then load=1 with load_value=3, then start (PRESCALE=1) -> count reads 3,2,1,0 on consecutive cycles after start. done is high only on the cycle count becomes 0. running falls on that same edge. zero=1 afterwards.
2. PRESCALE=3, load 2, start -> count 2 for 3 cycles, then 1 for 3 cycles, then 0. done pulses once, 6 cycles after start.
3. reload_en=1, load 2, start, run 8 cycles -> count sequence 2,1,2,1,2,1… with a done pulse every 2nd cycle. running stays 1 throughout.
4. load 5, start, stop after 2 decrements, hold 4 cycles, start again -> count freezes at 3 while stopped. It then resumes 3,2,1,0 with a single done pulse.
5. start and stop asserted together in IDLE with count=4 -> stays IDLE, count=4. Separately, start with count=0 -> one done pulse and running remains 0.
6. reset asserted mid-RUN with count=0x1234 -> next cycle count=0, running=0, done=0. Separately, load 0xFFFF at expiry -> count=0xFFFF, no done pulse.
7. dec16 unit test with vectors 0x0001->0x0000, 0x0000->0xFFFF, 0x8000->0x7FFF, 0xFFFF->0xFFFE -> all match. X output is flagged as a failure.
